alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_decode_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// Decodes RV32I ALU-class instructions into ALU requests behind a valid/ready handshake.
// Define ALU_DECODE_SKID_EN to build a 2-entry skid buffer with a registered in_ready.
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic        w_illegal;
  logic [2:0]  w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [67:0] w_dec;
  logic        w_push;
  logic        w_pop;

  logic [67:0] r_out;
  logic        r_outValid;
  logic [7:0]  r_illegalCnt;

  always_comb begin
    w_illegal = 1'b0;
    w_op      = OP_ADD;
    w_a       = rs1_data;
    w_b       = rs2_data;
    unique case (inst[6:0])
      7'b0110011: begin
        unique case ({inst[31:25], inst[14:12]})
          {F7_ZERO, 3'b000}: w_op = OP_ADD;
          {F7_ALT,  3'b000}: w_op = OP_SUB;
          {F7_ZERO, 3'b111}: w_op = OP_AND;
          {F7_ZERO, 3'b110}: w_op = OP_OR;
          {F7_ZERO, 3'b100}: w_op = OP_XOR;
          {F7_ZERO, 3'b001}: w_op = OP_SLL;
          {F7_ZERO, 3'b101}: w_op = OP_SRL;
          {F7_ALT,  3'b101}: w_op = OP_SRA;
          default:           w_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_b = {{20{inst[31]}}, inst[31:20]};
        unique case (inst[14:12])
          3'b000: w_op = OP_ADD;
          3'b111: w_op = OP_AND;
          3'b110: w_op = OP_OR;
          3'b100: w_op = OP_XOR;
          3'b001: begin
            w_op      = OP_SLL;
            w_b       = {27'b0, inst[24:20]};
            w_illegal = (inst[31:25] != F7_ZERO);
          end
          3'b101: begin
            w_op      = inst[30] ? OP_SRA : OP_SRL;
            w_b       = {27'b0, inst[24:20]};
            w_illegal = (inst[31:25] != F7_ZERO) && (inst[31:25] != F7_ALT);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      7'b0110111: begin
        w_a = 32'b0;
        w_b = {inst[31:12], 12'b0};
      end
      7'b0010111: begin
        w_a = pc;
        w_b = {inst[31:12], 12'b0};
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal requests carry a zeroed payload so the ALU sees a harmless add 0+0.
    if (w_illegal) begin
      w_op = OP_ADD;
      w_a  = 32'b0;
      w_b  = 32'b0;
    end
  end

  assign w_dec    = {w_illegal, w_op, w_a, w_b};
  assign w_push   = in_valid & in_ready;
  assign w_pop    = r_outValid & out_ready;

  assign out_valid   = r_outValid;
  assign illegal_cnt = r_illegalCnt;
  assign {illegal, alu_op, alu_a, alu_b} = r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegalCnt <= 8'h00;
    end else if (w_push && w_illegal && (r_illegalCnt != 8'hFF)) begin
      r_illegalCnt <= r_illegalCnt + 8'h01;
    end
  end

`ifdef ALU_DECODE_SKID_EN
  logic [67:0] r_skid;
  logic        r_skidValid;
  logic        r_inReady;
  logic [1:0]  w_occNext;

  // The skid slot only fills while the output slot is stalled, so it is always the younger entry.
  assign w_occNext = {1'b0, r_outValid} + {1'b0, r_skidValid} + {1'b0, w_push} - {1'b0, w_pop};
  assign in_ready  = r_inReady & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_outValid  <= 1'b0;
      r_skid      <= '0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
    end else begin
      if (!r_outValid || w_pop) begin
        if (r_skidValid) begin
          r_out       <= r_skid;
          r_outValid  <= 1'b1;
          r_skidValid <= w_push;
          if (w_push) begin
            r_skid <= w_dec;
          end
        end else begin
          r_outValid <= w_push;
          if (w_push) begin
            r_out <= w_dec;
          end
        end
      end else if (w_push) begin
        r_skid      <= w_dec;
        r_skidValid <= 1'b1;
      end
      r_inReady <= (w_occNext != 2'd2);
    end
  end
`else
  assign in_ready = ~rst & (~r_outValid | out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_outValid <= 1'b0;
    end else if (w_push) begin
      r_out      <= w_dec;
      r_outValid <= 1'b1;
    end else if (w_pop) begin
      r_outValid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: a mnemonic-level reference model feeds an expected queue
// that an independent output monitor drains.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  typedef struct packed {
    logic        ill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   modelCnt = 0;
  bit   randReady = 1'b0;

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Reference decode by mnemonic; the opcode number is the mnemonic's position in the ALU op table.
  function automatic exp_t refModel(input logic [31:0] i, input logic [31:0] p,
                                    input logic [31:0] r1, input logic [31:0] r2);
    string opNames[8] = '{"add", "sub", "and", "or", "xor", "sll", "srl", "sra"};
    string mn = "";
    exp_t  e;
    int    opc = int'(i[6:0]);
    int    f3  = int'(i[14:12]);
    int    f7  = int'(i[31:25]);
    logic [31:0] immI = {{20{i[31]}}, i[31:20]};
    logic [31:0] immU = i & 32'hFFFFF000;
    e = '0;
    e.a = r1;
    if (opc == 'h33) begin
      e.b = r2;
      if (f7 == 0) begin
        case (f3)
          0: mn = "add"; 1: mn = "sll"; 4: mn = "xor";
          5: mn = "srl"; 6: mn = "or";  7: mn = "and";
          default: mn = "";
        endcase
      end else if (f7 == 'h20) begin
        if (f3 == 0) mn = "sub";
        else if (f3 == 5) mn = "sra";
      end
    end else if (opc == 'h13) begin
      e.b = immI;
      case (f3)
        0: mn = "add"; 4: mn = "xor"; 6: mn = "or"; 7: mn = "and";
        1: if (f7 == 0) begin mn = "sll"; e.b = 32'(i[24:20]); end
        5: begin
          e.b = 32'(i[24:20]);
          if (f7 == 0) mn = "srl";
          else if (f7 == 'h20) mn = "sra";
        end
        default: mn = "";
      endcase
    end else if (opc == 'h37) begin
      mn = "add"; e.a = 32'd0; e.b = immU;
    end else if (opc == 'h17) begin
      mn = "add"; e.a = p; e.b = immU;
    end
    if (mn == "") begin
      e = '0;
      e.ill = 1'b1;
    end else begin
      for (int k = 0; k < 8; k++) if (opNames[k] == mn) e.op = 3'(k);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Offers one instruction until accepted; the expected response is queued on the accepting cycle.
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] r1, input logic [31:0] r2);
    bit   accepted = 1'b0;
    exp_t e;
    inst = i; pc = p; rs1_data = r1; rs2_data = r2;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        e = refModel(i, p, r1, r2);
        expQ.push_back(e);
        if (e.ill && modelCnt < 255) modelCnt++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    else checkOutput("illegal_cnt", 32'(illegal_cnt), 32'(modelCnt));
  endtask

  task automatic drain();
    int c = 0;
    while ((expQ.size() != 0 || out_valid) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    modelCnt = 0;
  endtask

  // Output monitor: pops on every output transfer and checks stability while stalled.
  initial begin
    bit   held = 1'b0;
    exp_t heldVal;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checkOutput("valid_held", 32'(out_valid), 32'd1);
          if (out_valid) checkOutput("stable", 32'({illegal, alu_op, alu_a} != {heldVal.ill, heldVal.op, heldVal.a} || alu_b != heldVal.b), 32'd0);
        end
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("sb_illegal", 32'(illegal), 32'(e.ill));
            checkOutput("sb_alu_op", 32'(alu_op), 32'(e.op));
            checkOutput("sb_alu_a", alu_a, e.a);
            checkOutput("sb_alu_b", alu_b, e.b);
          end
          held = 1'b0;
        end else if (out_valid) begin
          held = 1'b1;
          heldVal = {illegal, alu_op, alu_a, alu_b};
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] bpInst[3] = '{32'h002081B3, 32'h402081B3, 32'h0020A1B3};
    int          k;
    int          expAccepts;
    logic [31:0] ri;
    int          sel;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    applyStimulus(32'h002081B3, 32'h0, 32'd5, 32'd7);
    checkOutput("add_valid", 32'(out_valid), 32'd1);
    checkOutput("add_op", 32'(alu_op), 32'd0);
    checkOutput("add_a", alu_a, 32'd5);
    checkOutput("add_b", alu_b, 32'd7);
    checkOutput("add_illegal", 32'(illegal), 32'd0);

    applyStimulus(32'h402081B3, 32'h0, 32'd9, 32'd4);
    checkOutput("sub_op", 32'(alu_op), 32'd1);
    applyStimulus(32'h40315093, 32'h0, 32'hF0000000, 32'd0);
    checkOutput("srai_op", 32'(alu_op), 32'd7);
    checkOutput("srai_b", alu_b, 32'd3);

    applyStimulus(32'h123450B7, 32'h100, 32'hDEADBEEF, 32'd1);
    checkOutput("lui_a", alu_a, 32'd0);
    checkOutput("lui_b", alu_b, 32'h12345000);
    checkOutput("lui_op", 32'(alu_op), 32'd0);
    applyStimulus(32'h12345097, 32'h100, 32'hDEADBEEF, 32'd1);
    checkOutput("auipc_a", alu_a, 32'h100);
    checkOutput("auipc_b", alu_b, 32'h12345000);
    drain();

    doReset();
    checkOutput("slt_cnt_before", 32'(illegal_cnt), 32'd0);
    applyStimulus(32'h0020A1B3, 32'h0, 32'd1, 32'd2);
    checkOutput("slt_illegal", 32'(illegal), 32'd1);
    checkOutput("slt_op", 32'(alu_op), 32'd0);
    checkOutput("slt_cnt_after", 32'(illegal_cnt), 32'd1);
    for (int n = 0; n < 300; n++) applyStimulus(32'h0020A1B3, 32'(n), $urandom, $urandom);
    checkOutput("cnt_saturated", 32'(illegal_cnt), 32'hFF);
    drain();

    // Backpressure: three instructions offered while the ALU stalls for five cycles.
`ifdef ALU_DECODE_SKID_EN
    expAccepts = 2;
`else
    expAccepts = 1;
`endif
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      inst = bpInst[k]; pc = 32'(k); rs1_data = 32'(10 + k); rs2_data = 32'(20 + k);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(refModel(inst, pc, rs1_data, rs2_data));
        if (refModel(inst, pc, rs1_data, rs2_data).ill && modelCnt < 255) modelCnt++;
        k++;
      end
      @(posedge clk); #1;
    end
    checkOutput("bp_accepted", 32'(k), 32'(expAccepts));
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 3; c++) begin
      inst = bpInst[k]; pc = 32'(k); rs1_data = 32'(10 + k); rs2_data = 32'(20 + k);
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(refModel(inst, pc, rs1_data, rs2_data));
        if (refModel(inst, pc, rs1_data, rs2_data).ill && modelCnt < 255) modelCnt++;
        k++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_all_accepted", 32'(k), 32'd3);
    drain();

    // Reset while a request is stalled on the outputs; it must never be delivered.
    out_ready = 1'b0;
    applyStimulus(32'h0020C1B3, 32'h0, 32'h11, 32'h22);
    checkOutput("rst_mid_valid_before", 32'(out_valid), 32'd1);
    rst = 1'b1;
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_cnt", 32'(illegal_cnt), 32'd0);
    expQ.delete();
    modelCnt = 0;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_mid_no_ghost", 32'(out_valid), 32'd0);

    // Randomized mix with random downstream stalls.
    randReady = 1'b1;
    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1: ri[6:0] = 7'h33;
        2, 3: ri[6:0] = 7'h13;
        4: ri[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
        default: ri[6:0] = 7'($urandom);
      endcase
      sel = $urandom_range(0, 3);
      if (sel < 2) ri[31:25] = 7'h00;
      else if (sel == 2) ri[31:25] = 7'h20;
      applyStimulus(ri, $urandom, $urandom, $urandom);
    end
    randReady = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
